// File: rtl/rgbw_hue_engine.sv
// rgbw_hue_engine: converts a hue index, white level and intensity into RGBW
// channel levels (or passes direct RGBW through), then applies a proportional
// intensity scale with a shift-add multiplier. One request at a time,
// start/busy/out_valid handshake.
module rgbw_hue_engine #(
  parameter int DW      = 8,
  parameter int STEP    = 7,
  parameter int SEG_LEN = 36,
  parameter int IDXW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [IDXW-1:0] hue_idx,
  input  logic [DW-1:0]   lint,
  input  logic [DW-1:0]   white_in,
  input  logic [DW-1:0]   red_in,
  input  logic [DW-1:0]   green_in,
  input  logic [DW-1:0]   blue_in,
  output logic            busy,
  output logic            out_valid,
  output logic [DW-1:0]   red_out,
  output logic [DW-1:0]   green_out,
  output logic [DW-1:0]   blue_out,
  output logic [DW-1:0]   white_out
);

  localparam logic [DW-1:0]   MAX      = {DW{1'b1}};
  localparam logic [DW-1:0]   ZERO     = {DW{1'b0}};
  localparam int              HMAX     = 6 * SEG_LEN - 1;
  localparam int              CW       = IDXW + 1;
  localparam int              SCW      = $clog2(DW + 1);
  localparam logic [IDXW-1:0] HMAX_IDX = IDXW'(HMAX);
  localparam logic [IDXW-1:0] POS_LAST = IDXW'(SEG_LEN - 1);
  localparam logic [SCW-1:0]  SC_LAST  = SCW'(DW);
  // A step larger than full scale simply saturates on the first increment.
  localparam logic [DW-1:0]   STEP_C   = (STEP >= (2 ** DW) - 1) ? MAX : DW'(STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HUE   = 3'd1,
    S_MIX   = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Saturating add: the sum is formed one bit wider so it can never wrap.
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? MAX : s[DW-1:0];
  endfunction

  // Colour-wheel lookup from segment number and current ramp value.
  function automatic logic [3*DW-1:0] hue_rgb(input logic [2:0] seg, input logic [DW-1:0] rise);
    logic [DW-1:0]   fall;
    logic [3*DW-1:0] res;
    fall = MAX - rise;
    res  = '0;
    case (seg)
      3'd0:    res = {MAX,  ZERO, rise};
      3'd1:    res = {fall, ZERO, MAX };
      3'd2:    res = {ZERO, rise, MAX };
      3'd3:    res = {ZERO, MAX,  fall};
      3'd4:    res = {rise, MAX,  ZERO};
      3'd5:    res = {MAX,  fall, ZERO};
      default: res = '0;
    endcase
    return res;
  endfunction

  state_t              state_q, state_nx;
  logic                run_q;
  logic                start_ok;
  logic [1:0]          mode_q;
  logic [DW-1:0]       lint_q;
  logic [IDXW-1:0]     idx_q;
  logic [IDXW-1:0]     idx_clamp;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          seg_q;
  logic [IDXW-1:0]     pos_q;
  logic [DW-1:0]       rise_q;
  logic [SCW-1:0]      sc_q;
  logic [DW-1:0]       ml_q;
  logic [DW-1:0]       ch_q   [4];
  logic [2*DW-1:0]     acc_q  [4];
  logic [2*DW-1:0]     mcd_q  [4];
  logic [2*DW-1:0]     acc_nx [4];
  logic [3*DW-1:0]     rgb_w;
  logic                hue_last;
  logic                scale_last;

  assign start_ok   = start && run_q;
  assign idx_clamp  = (hue_idx > HMAX_IDX) ? HMAX_IDX : hue_idx;
  assign hue_last   = (cnt_q == {1'b0, idx_q});
  assign scale_last = (sc_q == SC_LAST);
  assign rgb_w      = hue_rgb(seg_q, rise_q);
  assign busy       = (state_q != S_IDLE);

  // Reset-release qualifier: blocks acceptance on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_nx = mode[0] ? S_HUE : S_SCALE;
      S_HUE:   if (hue_last) state_nx = S_MIX;
      S_MIX:   state_nx = S_SCALE;
      S_SCALE: if (scale_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // One shift-add step per channel: add the shifted channel when the current
  // intensity bit is set.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_nx[i] = acc_q[i] + (ml_q[0] ? mcd_q[i] : {2*DW{1'b0}});
    end
  end

  // Datapath: capture, hue walk, white mix, intensity scale and output load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= '0;
      lint_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      seg_q     <= '0;
      pos_q     <= '0;
      rise_q    <= '0;
      sc_q      <= '0;
      ml_q      <= '0;
      out_valid <= 1'b0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      white_out <= '0;
      for (int i = 0; i < 4; i++) begin
        ch_q[i]  <= '0;
        acc_q[i] <= '0;
        mcd_q[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            mode_q  <= mode;
            lint_q  <= lint;
            idx_q   <= idx_clamp;
            ch_q[0] <= red_in;
            ch_q[1] <= green_in;
            ch_q[2] <= blue_in;
            ch_q[3] <= white_in;
            cnt_q   <= '0;
            seg_q   <= '0;
            pos_q   <= '0;
            rise_q  <= '0;
            sc_q    <= '0;
          end
        end
        S_HUE: begin
          if (hue_last) begin
            ch_q[0] <= rgb_w[3*DW-1:2*DW];
            ch_q[1] <= rgb_w[2*DW-1:DW];
            ch_q[2] <= rgb_w[DW-1:0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (pos_q == POS_LAST) begin
              pos_q  <= '0;
              seg_q  <= seg_q + 3'd1;
              rise_q <= '0;
            end else begin
              pos_q  <= pos_q + 1'b1;
              rise_q <= sat_add(rise_q, STEP_C);
            end
          end
        end
        S_MIX: begin
          if (mode_q[1]) begin
            ch_q[0] <= sat_add(ch_q[0], ch_q[3]);
            ch_q[1] <= sat_add(ch_q[1], ch_q[3]);
            ch_q[2] <= sat_add(ch_q[2], ch_q[3]);
          end
        end
        S_SCALE: begin
          if (sc_q == '0) begin
            // c*(lint+1) = c*lint + c: seed the product with c itself.
            for (int i = 0; i < 4; i++) begin
              acc_q[i] <= {ZERO, ch_q[i]};
              mcd_q[i] <= {ZERO, ch_q[i]};
            end
            ml_q <= lint_q;
          end else begin
            for (int i = 0; i < 4; i++) begin
              acc_q[i] <= acc_nx[i];
              mcd_q[i] <= mcd_q[i] << 1;
            end
            ml_q <= ml_q >> 1;
          end
          sc_q <= sc_q + 1'b1;
          if (scale_last) begin
            red_out   <= acc_nx[0][2*DW-1:DW];
            green_out <= acc_nx[1][2*DW-1:DW];
            blue_out  <= acc_nx[2][2*DW-1:DW];
            white_out <= acc_nx[3][2*DW-1:DW];
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
